clock_divide_prog: RTL and testbench

- Runtime-programmable integer clock divider; successor to the fixed divide-by-2, even and odd dividers.
- One instance covers any divisor from 2 to 2^WIDTH-1 with exact 50% duty (odd divisors use a half-cycle negedge term).
- Adds a run/stop enable, glitch-free divisor reload at period boundaries, a reference-domain tick strobe and a config-error flag.
- Sits between the system clock and slow peripheral/clock-enable consumers.

---
 rtl/clock_divide_prog.sv | 128 ++++++++++++
 tb/tb_clock_divide_prog.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divide_prog.sv
// Runtime-programmable integer clock divider with exact 50% duty.
// Odd divisors add a half-cycle negedge term; reloads land on period boundaries.
module clock_divide_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend,
  output logic             cfg_err
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(RESET_DIV);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_cur;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pend;
  logic             r_cfg_err;
  logic             r_pos;
  logic             r_neg;
  logic             r_tick;

  logic             w_bad;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_last;
  logic [WIDTH-1:0] w_next_div;

  assign w_bad      = div_in < DIV_MIN;
  assign w_load_val = w_bad ? DIV_MIN : div_in;
  // floor(N/2) is H for both even and odd N
  assign w_half     = r_div_cur >> 1;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last     = r_cnt == (r_div_cur - 1'b1);
  assign w_next_div = div_load ? w_load_val :
                      r_pend   ? r_pend_div : r_div_cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div_cur  <= DIV_RST;
      r_pend_div <= DIV_RST;
      r_pend     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_pos      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      if (div_load) begin
        r_cfg_err <= w_bad;
      end
      unique case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_pend <= 1'b0;
          if (div_load) begin
            r_div_cur <= w_load_val;
          end
          if (en) begin
            r_state <= S_RUN;
            r_pos   <= 1'b1;
            r_tick  <= 1'b1;
          end else begin
            r_pos  <= 1'b0;
            r_tick <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_last) begin
            r_cnt  <= w_cnt_inc;
            r_pos  <= w_cnt_inc < w_half;
            r_tick <= 1'b0;
            if (div_load) begin
              r_pend_div <= w_load_val;
              r_pend     <= 1'b1;
            end
          end else begin
            // boundary: a same-edge load beats the pending value
            r_div_cur <= w_next_div;
            r_pend    <= 1'b0;
            r_cnt     <= '0;
            if (en) begin
              r_pos  <= 1'b1;
              r_tick <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_pos   <= 1'b0;
              r_tick  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= r_pos;
    end
  end

  assign clk_out = r_div_cur[0] ? (r_pos | r_neg) : r_pos;
  assign tick    = r_tick;
  assign div_cur = r_div_cur;
  assign pend    = r_pend;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_clock_divide_prog.sv
// Bench for clock_divide_prog: half-cycle output model plus
// hand-computed period/duty and status expectations.
`timescale 1ns/1ps
module tb_clock_divide_prog;

  localparam int W  = 8;
  localparam int RD = 2;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         en       = 1'b0;
  logic [W-1:0] div_in   = '0;
  logic         div_load = 1'b0;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] div_cur;
  logic         pend;
  logic         cfg_err;

  int errs   = 0;
  int checks = 0;

  clock_divide_prog #(
    .WIDTH    (W),
    .RESET_DIV(RD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur),
    .pend    (pend),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: period of N cycles, output high for the first N half-cycles
  bit m_run  = 1'b0;
  int m_n    = RD;
  int m_k    = 0;
  bit m_pend = 1'b0;
  int m_pv   = RD;
  bit m_err  = 1'b0;

  function automatic int clamp(input logic [W-1:0] v);
    return (int'(v) < 2) ? 2 : int'(v);
  endfunction

  function automatic logic exp_clk(input int half);
    return m_run && ((2 * m_k + half) < m_n);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run  <= 1'b0;
      m_n    <= RD;
      m_k    <= 0;
      m_pend <= 1'b0;
      m_pv   <= RD;
      m_err  <= 1'b0;
    end else begin
      if (div_load) m_err <= (int'(div_in) < 2);
      if (!m_run) begin
        if (div_load) m_n <= clamp(div_in);
        if (en) begin
          m_run <= 1'b1;
          m_k   <= 0;
        end
      end else if (m_k < m_n - 1) begin
        m_k <= m_k + 1;
        if (div_load) begin
          m_pend <= 1'b1;
          m_pv   <= clamp(div_in);
        end
      end else begin
        m_n    <= div_load ? clamp(div_in) : (m_pend ? m_pv : m_n);
        m_pend <= 1'b0;
        m_k    <= 0;
        if (!en) m_run <= 1'b0;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    chk("m_clk_out_hi", 32'(clk_out), 32'(exp_clk(0)));
    chk("m_tick", 32'(tick), 32'(m_run && (m_k == 0)));
    chk("m_div_cur", 32'(div_cur), 32'(m_n));
    chk("m_pend", 32'(pend), 32'(m_pend));
    chk("m_cfg_err", 32'(cfg_err), 32'(m_err));
    @(negedge clk);
    #1;
    chk("m_clk_out_lo", 32'(clk_out), 32'(exp_clk(1)));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic load(input int v);
    step();
    div_in   = W'(v);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (tick === 1'b1) return;
    end
    chk("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure(input string nm, input int budget,
                         input int exp_per, input int exp_hi);
    logic prev;
    logic cur;
    int   st;
    int   t_r1;
    int   t_f;
    prev = clk_out;
    st   = 0;
    t_r1 = 0;
    t_f  = 0;
    for (int i = 0; i < budget; i++) begin
      @(clk);
      #1;
      cur = clk_out;
      if (cur !== prev) begin
        if (st == 0 && cur === 1'b1) begin
          t_r1 = int'($time) - 1;
          st   = 1;
        end else if (st == 1 && cur === 1'b0) begin
          t_f = int'($time) - 1;
          st  = 2;
        end else if (st == 2 && cur === 1'b1) begin
          chk({nm, "_period"}, 32'(int'($time) - 1 - t_r1), 32'(exp_per));
          chk({nm, "_high"}, 32'(t_f - t_r1), 32'(exp_hi));
          return;
        end
      end
      prev = cur;
    end
    chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int   tstart;
    int   tfall;
    int   nrise;
    logic prev;
    #2 rst = 1'b0;
    #15 rst = 1'b1;
    step();
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_div_cur", 32'(div_cur), 32'd2);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);

    load(6);
    chk("idle_load_div", 32'(div_cur), 32'd6);
    chk("idle_load_pend", 32'(pend), 32'd0);
    en = 1'b1;
    wait_tick(4);
    chk("start_tick", 32'(tick), 32'd1);
    measure("n6", 40, 60, 30);

    wait_tick(10);
    load(5);
    chk("run_load_pend", 32'(pend), 32'd1);
    chk("run_load_hold", 32'(div_cur), 32'd6);
    wait_tick(10);
    chk("n5_applied", 32'(div_cur), 32'd5);
    chk("n5_pend_clr", 32'(pend), 32'd0);
    measure("n5", 40, 50, 25);

    load(3);
    wait_tick(10);
    measure("n3", 30, 30, 15);
    load(255);
    wait_tick(10);
    chk("n255_applied", 32'(div_cur), 32'd255);
    measure("n255", 1200, 2550, 1275);

    load(4);
    wait_tick(600);
    chk("n4_applied", 32'(div_cur), 32'd4);
    step();
    div_in   = 8'd7;
    div_load = 1'b1;
    step();
    div_in   = 8'd9;
    step();
    div_load = 1'b0;
    chk("two_load_pend", 32'(pend), 32'd1);
    chk("two_load_hold", 32'(div_cur), 32'd4);
    step();
    chk("last_wins_div", 32'(div_cur), 32'd9);
    chk("last_wins_tick", 32'(tick), 32'd1);
    measure("n9", 60, 90, 45);

    wait_tick(12);
    repeat (8) step();
    div_in   = 8'd4;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("bnd_load_div", 32'(div_cur), 32'd4);
    chk("bnd_load_tick", 32'(tick), 32'd1);
    chk("bnd_load_pend", 32'(pend), 32'd0);

    load(1);
    chk("bad_cfg_err", 32'(cfg_err), 32'd1);
    wait_tick(10);
    chk("bad_clamp", 32'(div_cur), 32'd2);
    measure("n2", 20, 20, 10);
    load(4);
    chk("good_cfg_err", 32'(cfg_err), 32'd0);
    wait_tick(10);
    measure("n4", 30, 40, 20);

    load(6);
    wait_tick(12);
    step();
    en     = 1'b0;
    tstart = int'($time) - 17;
    tfall  = -1;
    nrise  = 0;
    prev   = clk_out;
    for (int i = 0; i < 40; i++) begin
      @(clk);
      #1;
      if (clk_out === 1'b0 && prev === 1'b1 && tfall < 0) tfall = int'($time) - 1;
      if (clk_out === 1'b1 && prev === 1'b0) nrise++;
      prev = clk_out;
    end
    chk("en_off_fall", 32'(tfall - tstart), 32'd30);
    chk("en_off_rise", 32'(nrise), 32'd0);
    step();
    chk("en_off_tick", 32'(tick), 32'd0);
    chk("en_off_clk", 32'(clk_out), 32'd0);

    en = 1'b1;
    wait_tick(4);
    div_in   = 8'd0;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("pre_rst_pend", 32'(pend), 32'd1);
    chk("pre_rst_err", 32'(cfg_err), 32'd1);
    chk("pre_rst_clk", 32'(clk_out), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_clk", 32'(clk_out), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    chk("mid_rst_div", 32'(div_cur), 32'd2);
    chk("mid_rst_pend", 32'(pend), 32'd0);
    chk("mid_rst_err", 32'(cfg_err), 32'd0);
    repeat (3) step();
    chk("hold_rst_clk", 32'(clk_out), 32'd0);
    rst = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
